// File: rtl/seat_mem_pkg.sv
// seat_mem_pkg: shared types and default widths for the seat-assignment table.
//   seat_op_e    : request opcode (READ/ASSIGN/RELEASE/FIND)
//   seat_state_e : control FSM state (idle / sequential find scan)
package seat_mem_pkg;

  localparam int unsigned SEAT_W_DEF = 8;
  localparam int unsigned STU_W_DEF  = 25;

  typedef enum logic [1:0] {
    OpRead    = 2'b00,
    OpAssign  = 2'b01,
    OpRelease = 2'b10,
    OpFind    = 2'b11
  } seat_op_e;

  typedef enum logic {
    StIdle = 1'b0,
    StScan = 1'b1
  } seat_state_e;

endpackage

// File: rtl/seat_mem_if.sv
// seat_mem_if: request/response port of the seat table plus occupancy status.
//   master : seating controller (drives req_valid/op/seat/student)
//   slave  : seat_mem (drives req_ready, rsp_*, occ_count, full, empty)
interface seat_mem_if
  import seat_mem_pkg::*;
#(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned SEAT_W = SEAT_W_DEF,
  parameter int unsigned STU_W  = STU_W_DEF
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              req_valid;
  logic              req_ready;
  seat_op_e          req_op;
  logic [SEAT_W-1:0] req_seat;
  logic [STU_W-1:0]  req_student;
  logic              rsp_valid;
  logic              rsp_ok;
  logic [SEAT_W-1:0] rsp_seat;
  logic [STU_W-1:0]  rsp_student;
  logic [CNT_W-1:0]  occ_count;
  logic              full;
  logic              empty;

  modport master (
    output req_valid, req_op, req_seat, req_student,
    input  req_ready, rsp_valid, rsp_ok, rsp_seat, rsp_student, occ_count, full, empty
  );

  modport slave (
    input  req_valid, req_op, req_seat, req_student,
    output req_ready, rsp_valid, rsp_ok, rsp_seat, rsp_student, occ_count, full, empty
  );
endinterface

// File: rtl/seat_mem_ram.sv
// seat_mem_ram: DEPTH x STU_W student-number array, one synchronous write port and
// one combinational read port. Not reset; the caller keeps addresses in range.
//   clk_i   : clock          we_i/waddr_i/wdata_i : write port
//   raddr_i : read address   rdata_o              : read data
module seat_mem_ram #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned STU_W = 25,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [STU_W-1:0] wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [STU_W-1:0] rdata_o
);
  logic [STU_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/seat_mem.sv
// seat_mem: seat-assignment table with per-seat occupancy, read-back, release,
// conflict rejection and a sequential find-by-student scan (one entry per cycle).
//   clk_seat_mem   : clock, rising edge
//   reset_seat_mem : synchronous active-high reset
//   bus            : seat_mem_if.slave request/response port and status
// Build option: define SEAT_MEM_OVERWRITE_EN to let ASSIGN replace a seat held by
// a different student instead of rejecting it.
module seat_mem
  import seat_mem_pkg::*;
#(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned SEAT_W = SEAT_W_DEF,
  parameter int unsigned STU_W  = STU_W_DEF
) (
  input logic        clk_seat_mem,
  input logic        reset_seat_mem,
  seat_mem_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [SEAT_W:0]   DepthW  = (SEAT_W + 1)'(DEPTH);
  localparam logic [SEAT_W-1:0] LastIdx = SEAT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CntMax  = CNT_W'(DEPTH);

  seat_state_e       state_q, state_d;
  logic [SEAT_W-1:0] scan_q, scan_d;
  logic [STU_W-1:0]  key_q, key_d;
  logic [DEPTH-1:0]  occ_q, occ_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_ok_q, rsp_ok_d;
  logic [SEAT_W-1:0] rsp_seat_q, rsp_seat_d;
  logic [STU_W-1:0]  rsp_student_q, rsp_student_d;

  logic              ram_we;
  logic [IDX_W-1:0]  ram_raddr;
  logic [STU_W-1:0]  ram_rdata;

  logic [IDX_W-1:0]  seat_idx, scan_idx;
  logic              accept, in_range, occ_cur;

  assign seat_idx = bus.req_seat[IDX_W-1:0];
  assign scan_idx = scan_q[IDX_W-1:0];
  assign accept   = bus.req_valid && (state_q == StIdle);
  assign in_range = {1'b0, bus.req_seat} < DepthW;
  assign occ_cur  = in_range && occ_q[seat_idx];
  // The single read port serves the scan in SCAN and the addressed seat in IDLE.
  assign ram_raddr = (state_q == StScan) ? scan_idx : seat_idx;

  seat_mem_ram #(
    .DEPTH (DEPTH),
    .STU_W (STU_W),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk_i   (clk_seat_mem),
    .we_i    (ram_we),
    .waddr_i (seat_idx),
    .wdata_i (bus.req_student),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d       = state_q;
    scan_d        = scan_q;
    key_d         = key_q;
    occ_d         = occ_q;
    cnt_d         = cnt_q;
    rsp_valid_d   = 1'b0;
    rsp_ok_d      = rsp_ok_q;
    rsp_seat_d    = rsp_seat_q;
    rsp_student_d = rsp_student_q;
    ram_we        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept && bus.req_op == OpFind) begin
          state_d = StScan;
          scan_d  = '0;
          key_d   = bus.req_student;
        end else if (accept) begin
          rsp_valid_d   = 1'b1;
          rsp_seat_d    = bus.req_seat;
          rsp_ok_d      = 1'b0;
          rsp_student_d = '0;
          if (in_range) begin
            case (bus.req_op)
              OpRead: begin
                rsp_ok_d      = occ_cur;
                rsp_student_d = occ_cur ? ram_rdata : '0;
              end
              OpAssign: begin
                if (!occ_cur) begin
                  ram_we          = 1'b1;
                  occ_d[seat_idx] = 1'b1;
                  if (cnt_q != CntMax) cnt_d = cnt_q + CNT_W'(1);
                  rsp_ok_d        = 1'b1;
                  rsp_student_d   = bus.req_student;
                end else if (ram_rdata == bus.req_student) begin
                  rsp_ok_d      = 1'b1;
                  rsp_student_d = ram_rdata;
                end else begin
`ifdef SEAT_MEM_OVERWRITE_EN
                  ram_we        = 1'b1;
                  rsp_ok_d      = 1'b1;
                  rsp_student_d = bus.req_student;
`else
                  rsp_ok_d      = 1'b0;
                  rsp_student_d = ram_rdata;
`endif
                end
              end
              OpRelease: begin
                if (occ_cur) begin
                  occ_d[seat_idx] = 1'b0;
                  if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                  rsp_ok_d        = 1'b1;
                  rsp_student_d   = ram_rdata;
                end
              end
              default: ;
            endcase
          end
        end
      end
      StScan: begin
        if (occ_q[scan_idx] && ram_rdata == key_q) begin
          state_d       = StIdle;
          rsp_valid_d   = 1'b1;
          rsp_ok_d      = 1'b1;
          rsp_seat_d    = scan_q;
          rsp_student_d = key_q;
        end else if (scan_q == LastIdx) begin
          state_d       = StIdle;
          rsp_valid_d   = 1'b1;
          rsp_ok_d      = 1'b0;
          rsp_seat_d    = '0;
          rsp_student_d = '0;
        end else begin
          scan_d = scan_q + SEAT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_seat_mem) begin
    if (reset_seat_mem) begin
      state_q       <= StIdle;
      scan_q        <= '0;
      key_q         <= '0;
      occ_q         <= '0;
      cnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_ok_q      <= 1'b0;
      rsp_seat_q    <= '0;
      rsp_student_q <= '0;
    end else begin
      state_q       <= state_d;
      scan_q        <= scan_d;
      key_q         <= key_d;
      occ_q         <= occ_d;
      cnt_q         <= cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_ok_q      <= rsp_ok_d;
      rsp_seat_q    <= rsp_seat_d;
      rsp_student_q <= rsp_student_d;
    end
  end

  assign bus.req_ready   = (state_q == StIdle);
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_ok      = rsp_ok_q;
  assign bus.rsp_seat    = rsp_seat_q;
  assign bus.rsp_student = rsp_student_q;
  assign bus.occ_count   = cnt_q;
  assign bus.full        = (cnt_q == CntMax);
  assign bus.empty       = (cnt_q == '0);
endmodule

// File: tb/tb_seat_mem.sv
// tb_seat_mem: self-checking bench for seat_mem (directed table, corner sequences,
// randomized traffic against an array-based reference model).
module tb_seat_mem;
  import seat_mem_pkg::*;

  localparam int unsigned DEPTH  = 32;
  localparam int unsigned SEAT_W = 8;
  localparam int unsigned STU_W  = 25;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seat_mem_if #(.DEPTH(DEPTH), .SEAT_W(SEAT_W), .STU_W(STU_W)) bus ();

  seat_mem #(.DEPTH(DEPTH), .SEAT_W(SEAT_W), .STU_W(STU_W)) dut (
    .clk_seat_mem   (clk),
    .reset_seat_mem (rst),
    .bus            (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: occupancy flags and stored numbers per seat.
  bit               m_occ  [DEPTH];
  logic [STU_W-1:0] m_data [DEPTH];

  typedef struct {
    seat_op_e         op;
    logic [SEAT_W-1:0] seat;
    logic [STU_W-1:0] stu;
    logic             ok;
    logic [STU_W-1:0] exp_stu;
    int               cnt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(m_occ[i]);
    return c;
  endfunction

  // Applies the spec rules to the model and returns the expected response.
  task automatic model_op(input seat_op_e op, input logic [SEAT_W-1:0] seat,
                          input logic [STU_W-1:0] stu, output logic ok,
                          output logic [SEAT_W-1:0] rseat, output logic [STU_W-1:0] rstu,
                          output int lat);
    int s;
    s = int'(seat);
    ok = 1'b0; rstu = '0; rseat = seat; lat = 1;
    if (op == OpFind) begin
      rseat = '0;
      lat = DEPTH + 1;
      for (int i = 0; i < DEPTH; i++) begin
        if (m_occ[i] && m_data[i] == stu) begin
          ok = 1'b1; rseat = SEAT_W'(i); rstu = stu; lat = i + 2;
          break;
        end
      end
    end else if (s < DEPTH) begin
      case (op)
        OpRead: begin
          ok = m_occ[s]; rstu = m_occ[s] ? m_data[s] : '0;
        end
        OpAssign: begin
          if (!m_occ[s]) begin
            m_occ[s] = 1'b1; m_data[s] = stu; ok = 1'b1; rstu = stu;
          end else if (m_data[s] == stu) begin
            ok = 1'b1; rstu = stu;
          end else begin
`ifdef SEAT_MEM_OVERWRITE_EN
            m_data[s] = stu; ok = 1'b1; rstu = stu;
`else
            ok = 1'b0; rstu = m_data[s];
`endif
          end
        end
        OpRelease: begin
          if (m_occ[s]) begin
            m_occ[s] = 1'b0; ok = 1'b1; rstu = m_data[s];
          end
        end
        default: ;
      endcase
    end
  endtask

  // Issues one request (caller is #1 after a rising edge) and waits for the response.
  // lat counts rising edges from acceptance (inclusive) until rsp_valid is seen.
  task automatic issue(input seat_op_e op, input logic [SEAT_W-1:0] seat,
                       input logic [STU_W-1:0] stu, output logic ok,
                       output logic [SEAT_W-1:0] rseat, output logic [STU_W-1:0] rstu,
                       output int lat);
    int n = 0;
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_seat = seat; bus.req_student = stu;
    while (!bus.req_ready && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!bus.rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
    ok = bus.rsp_ok; rseat = bus.rsp_seat; rstu = bus.rsp_student;
  endtask

  vec_t vecs[12];

  initial begin
    logic ok, m_ok;
    logic [SEAT_W-1:0] rs, m_rs;
    logic [STU_W-1:0] rstu, m_rstu;
    int lat, m_lat;
    bit saw_rsp;

    vecs[0]  = '{OpRead,    8'd3,   25'd0,       1'b0, 25'd0,       0};
    vecs[1]  = '{OpAssign,  8'd5,   25'd2021001, 1'b1, 25'd2021001, 1};
    vecs[2]  = '{OpRead,    8'd5,   25'd0,       1'b1, 25'd2021001, 1};
`ifdef SEAT_MEM_OVERWRITE_EN
    vecs[3]  = '{OpAssign,  8'd5,   25'd2021002, 1'b1, 25'd2021002, 1};
    vecs[4]  = '{OpRead,    8'd5,   25'd0,       1'b1, 25'd2021002, 1};
`else
    vecs[3]  = '{OpAssign,  8'd5,   25'd2021002, 1'b0, 25'd2021001, 1};
    vecs[4]  = '{OpRead,    8'd5,   25'd0,       1'b1, 25'd2021001, 1};
`endif
    vecs[5]  = '{OpAssign,  8'd5,   25'd2021001, 1'b1, 25'd2021001, 1};
    vecs[6]  = '{OpRead,    8'd40,  25'd0,       1'b0, 25'd0,       1};
    vecs[7]  = '{OpAssign,  8'd32,  25'd7,       1'b0, 25'd0,       1};
    vecs[8]  = '{OpRelease, 8'd5,   25'd0,       1'b1, 25'd2021001, 0};
    vecs[9]  = '{OpRelease, 8'd5,   25'd0,       1'b0, 25'd0,       0};
    vecs[10] = '{OpRead,    8'd5,   25'd0,       1'b0, 25'd0,       0};
    vecs[11] = '{OpRelease, 8'd255, 25'd0,       1'b0, 25'd0,       0};

    bus.req_valid = 1'b0; bus.req_op = OpRead; bus.req_seat = '0; bus.req_student = '0;
    for (int i = 0; i < DEPTH; i++) begin m_occ[i] = 1'b0; m_data[i] = '0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_req_ready", bus.req_ready, 1);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_rsp_ok", bus.rsp_ok, 0);
    chk("reset_rsp_seat", bus.rsp_seat, 0);
    chk("reset_rsp_student", bus.rsp_student, 0);
    chk("reset_occ_count", bus.occ_count, 0);
    chk("reset_empty", bus.empty, 1);
    chk("reset_full", bus.full, 0);

    // Directed table.
    for (int v = 0; v < 12; v++) begin
      model_op(vecs[v].op, vecs[v].seat, vecs[v].stu, m_ok, m_rs, m_rstu, m_lat);
      issue(vecs[v].op, vecs[v].seat, vecs[v].stu, ok, rs, rstu, lat);
      chk($sformatf("vec%0d_ok", v), ok, vecs[v].ok);
      chk($sformatf("vec%0d_student", v), rstu, vecs[v].exp_stu);
      chk($sformatf("vec%0d_seat", v), rs, vecs[v].seat);
      chk($sformatf("vec%0d_latency", v), lat, 1);
      chk($sformatf("vec%0d_occ_count", v), bus.occ_count, vecs[v].cnt);
      chk($sformatf("vec%0d_empty", v), bus.empty, vecs[v].cnt == 0);
    end
    // Response fields hold after the pulse.
    @(posedge clk); #1;
    chk("hold_rsp_valid", bus.rsp_valid, 0);
    chk("hold_rsp_seat", bus.rsp_seat, 255);

    // Fill every seat, then find the last one (worst-case match latency).
    for (int i = 0; i < DEPTH; i++) begin
      model_op(OpAssign, SEAT_W'(i), STU_W'(2021000 + i), m_ok, m_rs, m_rstu, m_lat);
      issue(OpAssign, SEAT_W'(i), STU_W'(2021000 + i), ok, rs, rstu, lat);
      chk($sformatf("fill%0d_ok", i), ok, 1);
    end
    chk("fill_occ_count", bus.occ_count, DEPTH);
    chk("fill_full", bus.full, 1);
    chk("fill_empty", bus.empty, 0);
    issue(OpFind, 8'd0, 25'd2021031, ok, rs, rstu, lat);
    chk("find31_ok", ok, 1);
    chk("find31_seat", rs, 31);
    chk("find31_student", rstu, 2021031);
    chk("find31_latency", lat, DEPTH + 1);
    issue(OpFind, 8'd0, 25'd1234567, ok, rs, rstu, lat);
    chk("find_miss_ok", ok, 0);
    chk("find_miss_seat", rs, 0);
    chk("find_miss_student", rstu, 0);
    chk("find_miss_latency", lat, DEPTH + 1);
    issue(OpAssign, 8'd32, 25'd99, ok, rs, rstu, lat);
    chk("assign_oor_full_ok", ok, 0);
    chk("assign_oor_full_count", bus.occ_count, DEPTH);

    // Reset during a scan: target at seat 20, reset while index 10 is being tested.
    bus.req_valid = 1'b1; bus.req_op = OpFind; bus.req_seat = '0;
    bus.req_student = 25'd2021020;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    saw_rsp = 1'b0;
    repeat (10) begin
      if (bus.rsp_valid) saw_rsp = 1'b1;
      @(posedge clk); #1;
    end
    if (bus.rsp_valid) saw_rsp = 1'b1;
    chk("scan_busy_ready", bus.req_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_occ[i] = 1'b0;
    chk("abort_req_ready", bus.req_ready, 1);
    chk("abort_occ_count", bus.occ_count, 0);
    chk("abort_empty", bus.empty, 1);
    repeat (40) begin
      if (bus.rsp_valid) saw_rsp = 1'b1;
      @(posedge clk); #1;
    end
    chk("abort_no_rsp", saw_rsp, 0);
    issue(OpRead, 8'd20, 25'd0, ok, rs, rstu, lat);
    chk("abort_read20_ok", ok, 0);
    chk("abort_read20_student", rstu, 0);

    // Randomized traffic against the model.
    for (int t = 0; t < 300; t++) begin
      seat_op_e op;
      logic [SEAT_W-1:0] seat;
      logic [STU_W-1:0] stu;
      op   = seat_op_e'($urandom_range(0, 3));
      seat = SEAT_W'($urandom_range(0, 35));
      stu  = STU_W'(2021000 + $urandom_range(0, 5));
      model_op(op, seat, stu, m_ok, m_rs, m_rstu, m_lat);
      issue(op, seat, stu, ok, rs, rstu, lat);
      chk($sformatf("rnd%0d_ok", t), ok, m_ok);
      chk($sformatf("rnd%0d_seat", t), rs, m_rs);
      chk($sformatf("rnd%0d_student", t), rstu, m_rstu);
      chk($sformatf("rnd%0d_latency", t), lat, m_lat);
      chk($sformatf("rnd%0d_occ_count", t), bus.occ_count, m_count());
      chk($sformatf("rnd%0d_full", t), bus.full, m_count() == DEPTH);
      chk($sformatf("rnd%0d_empty", t), bus.empty, m_count() == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
